div_8: RTL
==========

Name: div_8

Overview:
- Iterative unsigned restoring divider. It is the inverse-operation companion to the team's ripple-carry adder datapath.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor.
- Produces one quotient bit per clock using a single subtract-and-restore step.
- Sits beside the adder in the arithmetic lab datapath, with a start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; captured when start accepted
- divisor  input  WIDTH  denominator; captured when start accepted
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  set with results when the captured divisor was 0

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. All internal registers and the iteration counter are cleared.
- Reset asserted mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k, divisor!=0:
  - Capture Q=dividend, R=0, D=divisor; counter=WIDTH-1; go to RUN.
- IDLE, start=1 at edge k, divisor==0:
  - Go directly to DONE.
  - Load quotient=all ones, remainder=dividend, div_by_zero=1.
  - done is high in the cycle after edge k.
- IDLE, start=0: stay in IDLE; outputs hold.
- RUN, each edge, one iteration:
  - Form S={R[WIDTH-2:0],Q[WIDTH-1]} as a WIDTH+1-bit value; compute T=S-{0,D}.
  - Subtraction is built as S + ~{0,D} + 1. Carry-out 1 means no borrow.
  - No borrow: R=T[WIDTH-1:0]; Q={Q[WIDTH-2:0],1}.
  - Borrow (restore): R=S[WIDTH-1:0]; Q={Q[WIDTH-2:0],0}.
  - Counter decrements. The iteration at counter==0 also loads quotient=Q_next, remainder=R_next, div_by_zero=0, and moves to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- busy=1 exactly in RUN, i.e. from edge k to edge k+WIDTH: WIDTH cycles.
- done=1 exactly in DONE:
  - the cycle after edge k+WIDTH for normal divides;
  - the cycle after edge k for divide-by-zero.
- start is ignored in RUN and DONE; no queuing. dividend and divisor may change freely after capture.
- Output hold: quotient/remainder/div_by_zero change only on entry to DONE. They hold through IDLE and through the following RUN until the next result.
- Maximum issue rate: one operation per WIDTH+2 cycles. A start asserted in the DONE cycle is dropped and must be held into IDLE.
- Invariant for divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.

Test Plan:
- Normal divide: start with dividend=200, divisor=7 → busy high 8 cycles; done pulses 8 cycles after start edge; quotient=28, remainder=4, div_by_zero=0.
- Boundary operands, each result held afterwards:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/255 → quotient=1, remainder=0.
  - 0/3 → quotient=0, remainder=0.
- Divide by zero: dividend=100, divisor=0 → done the cycle after start, busy never high; quotient=255, remainder=100, div_by_zero=1.
- Start ignored while busy: start 200/7, then pulse start with 9/3 during RUN.
  - Result is still 28 r 4; exactly one done pulse.
  - 9/3 is then issued from IDLE → 3 r 0.
- Reset mid-operation: start 200/7, drop rst_n after 4 cycles → outputs 0 immediately (asynchronously), state IDLE, no done.
  - After release, 17/5 → 3 r 2.
- Randomized sweep of 1000 operand pairs against a reference model (including divisor=0) → quotient/remainder match, invariant holds, done latency is WIDTH (or 1 for zero divisor).

Source files
------------

// File: rtl/div_8.sv
`default_nettype none
// div_8: iterative unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero short-circuits straight to DONE.
module div_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] d_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   s_w;
   logic [WIDTH+1:0] sum_w;
   logic             no_borrow_w;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] r_d;

   // Partial remainder stays below 2^(i) after iteration i, so R's MSB is
   // always zero when shifted and dropping it loses nothing.
   always_comb begin
      s_w         = {1'b0, r_q[WIDTH-2:0], q_q[WIDTH-1]};
      sum_w       = {1'b0, s_w} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
      no_borrow_w = sum_w[WIDTH+1];
      r_d         = no_borrow_w ? sum_w[WIDTH-1:0] : s_w[WIDTH-1:0];
      q_d         = {q_q[WIDTH-2:0], no_borrow_w};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         q_q         <= '0;
         r_q         <= '0;
         d_q         <= '0;
         cnt_q       <= CNT_ZERO;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     q_q     <= dividend;
                     r_q     <= '0;
                     d_q     <= divisor;
                     cnt_q   <= CNT_LAST;
                     busy    <= 1'b1;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ZERO) begin
                  quotient    <= q_d;
                  remainder   <= r_d;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
